// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage load/store unit: funct3 access types,
// FSM states and the fault / byte-lane decode helpers.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_WAIT = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // An access faults on conflicting direction, an undefined funct3 for its
  // direction, or a halfword/word address that is not naturally aligned.
  function automatic logic access_fault(input logic rd, input logic wr,
                                        input logic [2:0] f3, input logic [1:0] lo);
    logic legal_f3;
    logic aligned;
    if (rd) legal_f3 = f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    else    legal_f3 = f3 inside {F3_SB, F3_SH, F3_SW};
    case (f3[1:0])
      2'b01:   aligned = ~lo[0];
      2'b10:   aligned = (lo == 2'b00);
      default: aligned = 1'b1;
    endcase
    return (rd & wr) | ~legal_f3 | ~aligned;
  endfunction

  function automatic logic [3:0] lane_enable(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Combinational load formatter: picks the addressed byte/halfword lane of the
// read word and sign- or zero-extends it to 32 bits.
module load_formatter
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = rdata[8*gi +: 8];
  end

  assign byte_sel = lane[addr_lo];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = 32'h0;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   data = rdata;
      F3_LBU:  data = {24'h0, byte_sel};
      F3_LHU:  data = {16'h0, half_sel};
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one registered request/ready transaction per
// accepted access, with fault decode, store lane replication and BUSY stall.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic              misaligned,
  output logic [31:0]       load_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_byte_en,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata
);

  lsu_state_t        state_reg, state_next;
  logic [2:0]        funct3_reg;
  logic [1:0]        addr_lo_reg;
  logic              misaligned_reg;
  logic [31:0]       load_data_reg;
  logic              dmem_req_reg;
  logic              dmem_we_reg;
  logic [ADDR_W-1:0] dmem_addr_reg;
  logic [31:0]       dmem_wdata_reg;
  logic [3:0]        dmem_byte_en_reg;

  logic              accept;
  logic              fault;
  logic [31:0]       store_wdata;
  logic [31:0]       fmt_data;

  assign accept = valid & (mem_read | mem_write);
  assign fault  = access_fault(mem_read, mem_write, funct3, address[1:0]);

  always_comb begin
    case (funct3[1:0])
      2'b00:   store_wdata = {4{store_data[7:0]}};
      2'b01:   store_wdata = {2{store_data[15:0]}};
      default: store_wdata = store_data;
    endcase
  end

  load_formatter u_load_formatter (
    .funct3  (funct3_reg),
    .addr_lo (addr_lo_reg),
    .rdata   (dmem_rdata),
    .data    (fmt_data)
  );

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    case (state_reg)
      LSU_IDLE: if (accept) begin
        busy       = 1'b1;
        state_next = fault ? LSU_RESP : LSU_WAIT;
      end
      LSU_WAIT: begin
        busy = 1'b1;
        if (dmem_ready) state_next = LSU_RESP;
      end
      LSU_RESP: state_next = LSU_IDLE;
      default:  state_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg        <= LSU_IDLE;
      funct3_reg       <= 3'h0;
      addr_lo_reg      <= 2'h0;
      misaligned_reg   <= 1'b0;
      load_data_reg    <= 32'h0;
      dmem_req_reg     <= 1'b0;
      dmem_we_reg      <= 1'b0;
      dmem_addr_reg    <= '0;
      dmem_wdata_reg   <= 32'h0;
      dmem_byte_en_reg <= 4'h0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        LSU_IDLE: if (accept) begin
          funct3_reg     <= funct3;
          addr_lo_reg    <= address[1:0];
          misaligned_reg <= fault;
          load_data_reg  <= 32'h0;
          // Faulting accesses never reach memory, so the bus stays quiet.
          if (!fault) begin
            dmem_req_reg     <= 1'b1;
            dmem_we_reg      <= mem_write;
            dmem_addr_reg    <= {address[ADDR_W-1:2], 2'b00};
            dmem_byte_en_reg <= lane_enable(funct3, address[1:0]);
            dmem_wdata_reg   <= mem_write ? store_wdata : 32'h0;
          end
        end
        LSU_WAIT: if (dmem_ready) begin
          dmem_req_reg <= 1'b0;
          if (!dmem_we_reg) load_data_reg <= fmt_data;
        end
        default: ;
      endcase
    end
  end

  assign done         = (state_reg == LSU_RESP);
  assign misaligned   = done & misaligned_reg;
  assign load_data    = load_data_reg;
  assign dmem_req     = dmem_req_reg;
  assign dmem_we      = dmem_we_reg;
  assign dmem_addr    = dmem_addr_reg;
  assign dmem_wdata   = dmem_wdata_reg;
  assign dmem_byte_en = dmem_byte_en_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed test-plan steps, a unit
// test of load_formatter, then randomized accesses against a reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] address, store_data;
  logic        busy, done, misaligned;
  logic [31:0] load_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_byte_en;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  logic [2:0]  fmt_f3;
  logic [1:0]  fmt_lo;
  logic [31:0] fmt_rdata, fmt_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .address(address),
    .store_data(store_data), .busy(busy), .done(done), .misaligned(misaligned),
    .load_data(load_data), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_byte_en(dmem_byte_en),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
  );

  load_formatter u_fmt (
    .funct3(fmt_f3), .addr_lo(fmt_lo), .rdata(fmt_rdata), .data(fmt_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model: byte counts and arithmetic, not lane muxes ----
  function automatic int access_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic ref_fault(input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [31:0] a);
    int n;
    if (rd && wr) return 1'b1;
    if (f3[1:0] == 2'b11) return 1'b1;
    if (wr && f3[2]) return 1'b1;
    if (f3 == 3'b110) return 1'b1;
    n = access_bytes(f3);
    return (int'(a[1:0]) % n) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] rd);
    int n;
    longint v, span;
    n = access_bytes(f3);
    v = longint'(rd) >> (8 * int'(lo));
    if (n < 4) begin
      span = 64'sd1 << (8 * n);
      v = v % span;
      if (!f3[2] && v >= span / 2) v = v - span;
    end
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_byte_en(input logic [2:0] f3, input logic [1:0] lo);
    int m;
    m = ((1 << access_bytes(f3)) - 1) << int'(lo);
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] r;
    int n;
    n = access_bytes(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % n) +: 8];
    return r;
  endfunction

  // One access from accept through the cycle after DONE; w = READY wait cycles.
  task automatic run_op(input string tag, input logic v, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rdata, input int w);
    logic acc, flt;
    acc = v && (rd || wr);
    flt = ref_fault(rd, wr, f3, a);
    valid = v; mem_read = rd; mem_write = wr; funct3 = f3; address = a;
    store_data = sd; dmem_ready = 1'b0;
    #1;
    chk({tag, ".busy_t"}, {31'b0, busy}, {31'b0, acc});
    chk({tag, ".req_t"}, {31'b0, dmem_req}, 32'h0);
    @(posedge clk); #1;
    valid = 1'b0; mem_read = 1'b1; address = $urandom; store_data = $urandom;
    funct3 = 3'($urandom_range(0, 7));
    $display("[TB] %s v=%0b rd=%0b wr=%0b f3=%0d addr=%h sd=%h rdata=%h wait=%0d",
             tag, v, rd, wr, f3, a, sd, rdata, w);
    if (!acc) begin
      chk({tag, ".idle_done"}, {31'b0, done}, 32'h0);
      chk({tag, ".idle_req"}, {31'b0, dmem_req}, 32'h0);
      chk({tag, ".idle_busy"}, {31'b0, busy}, 32'h0);
      return;
    end
    if (flt) begin
      chk({tag, ".flt_done"}, {31'b0, done}, 32'h1);
      chk({tag, ".flt_mis"}, {31'b0, misaligned}, 32'h1);
      chk({tag, ".flt_ld"}, load_data, 32'h0);
      chk({tag, ".flt_req"}, {31'b0, dmem_req}, 32'h0);
      chk({tag, ".flt_busy"}, {31'b0, busy}, 32'h0);
    end else begin
      for (int i = 0; i <= w; i++) begin
        chk({tag, ".req"}, {31'b0, dmem_req}, 32'h1);
        chk({tag, ".we"}, {31'b0, dmem_we}, {31'b0, wr});
        chk({tag, ".addr"}, dmem_addr, {a[31:2], 2'b00});
        chk({tag, ".be"}, {28'b0, dmem_byte_en}, {28'b0, ref_byte_en(f3, a[1:0])});
        if (wr) chk({tag, ".wdata"}, dmem_wdata, ref_wdata(f3, sd));
        chk({tag, ".busy_w"}, {31'b0, busy}, 32'h1);
        chk({tag, ".done_w"}, {31'b0, done}, 32'h0);
        dmem_ready = (i == w);
        dmem_rdata = (i == w) ? rdata : $urandom;
        @(posedge clk); #1;
      end
      dmem_ready = 1'b0;
      chk({tag, ".done"}, {31'b0, done}, 32'h1);
      chk({tag, ".mis"}, {31'b0, misaligned}, 32'h0);
      chk({tag, ".ld"}, load_data, wr ? 32'h0 : ref_load(f3, a[1:0], rdata));
      chk({tag, ".req_r"}, {31'b0, dmem_req}, 32'h0);
      chk({tag, ".busy_r"}, {31'b0, busy}, 32'h0);
    end
    @(posedge clk); #1;
    chk({tag, ".pulse"}, {31'b0, done}, 32'h0);
  endtask

  initial begin
    logic [2:0] legal_ld [5];
    legal_ld = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    resetn = 1'b0; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'h0; address = 32'h0; store_data = 32'h0;
    dmem_ready = 1'b0; dmem_rdata = 32'h0;
    fmt_f3 = 3'h0; fmt_lo = 2'h0; fmt_rdata = 32'h0;
    #1;
    chk("rst.busy", {31'b0, busy}, 32'h0);
    chk("rst.done", {31'b0, done}, 32'h0);
    chk("rst.mis", {31'b0, misaligned}, 32'h0);
    chk("rst.ld", load_data, 32'h0);
    chk("rst.req", {31'b0, dmem_req}, 32'h0);
    chk("rst.we", {31'b0, dmem_we}, 32'h0);
    chk("rst.addr", dmem_addr, 32'h0);
    chk("rst.wdata", dmem_wdata, 32'h0);
    chk("rst.be", {28'b0, dmem_byte_en}, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Directed test-plan steps
    run_op("sw100", 1, 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    run_op("lb103", 1, 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FFFF7F, 3);
    chk("lb103.value", load_data, 32'hFFFFFF80);
    run_op("lbu102", 1, 1, 0, 3'b100, 32'h102, 32'h0, 32'h81234567, 1);
    chk("lbu102.value", load_data, 32'h00000023);
    run_op("lhu102", 1, 1, 0, 3'b101, 32'h102, 32'h0, 32'h81234567, 0);
    chk("lhu102.value", load_data, 32'h00008123);
    run_op("lh102", 1, 1, 0, 3'b001, 32'h102, 32'h0, 32'h81234567, 2);
    chk("lh102.value", load_data, 32'hFFFF8123);
    run_op("sh102", 1, 0, 1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 1);
    chk("sh102.wdata", dmem_wdata, 32'hABCDABCD);
    chk("sh102.be", {28'b0, dmem_byte_en}, 32'hC);
    run_op("sh101", 1, 0, 1, 3'b001, 32'h101, 32'h0000ABCD, 32'h0, 0);
    run_op("novalid", 0, 1, 0, 3'b010, 32'h200, 32'h0, 32'h0, 0);
    run_op("rdwr", 1, 1, 1, 3'b010, 32'h200, 32'h0, 32'h0, 0);

    // Reset while a load is waiting on memory
    valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; address = 32'h300;
    @(posedge clk); #1;
    valid = 1'b0;
    chk("rstwait.req_before", {31'b0, dmem_req}, 32'h1);
    resetn = 1'b0;
    #1;
    chk("rstwait.req", {31'b0, dmem_req}, 32'h0);
    chk("rstwait.busy", {31'b0, busy}, 32'h0);
    chk("rstwait.done", {31'b0, done}, 32'h0);
    $display("[TB] rstwait reset asserted during WAIT");
    @(posedge clk); #1;
    resetn = 1'b1;
    run_op("lw200", 1, 1, 0, 3'b010, 32'h200, 32'h0, 32'h5A5AC3C3, 0);
    chk("lw200.value", load_data, 32'h5A5AC3C3);

    // Formatter on its own
    for (int i = 0; i < 16; i++) begin
      int n, lo;
      fmt_f3 = legal_ld[$urandom_range(0, 4)];
      n = access_bytes(fmt_f3);
      lo = $urandom_range(0, 3);
      lo = lo - lo % n;
      fmt_lo = 2'(lo);
      fmt_rdata = $urandom;
      #1;
      $display("[TB] fmt f3=%0d lo=%0d rdata=%h out=%h", fmt_f3, fmt_lo, fmt_rdata, fmt_out);
      chk("fmt", fmt_out, ref_load(fmt_f3, fmt_lo, fmt_rdata));
    end

    // Randomized accesses
    for (int i = 0; i < 40; i++) begin
      int sel;
      logic v, rd, wr;
      v   = ($urandom_range(0, 7) != 0);
      sel = $urandom_range(0, 7);
      rd  = (sel <= 2) || (sel == 6);
      wr  = (sel >= 3) && (sel <= 6);
      run_op("rand", v, rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
